// File: rtl/rm_bist_pkg.sv
// Shared definitions for the March C- BIST controller: FSM states,
// element index type and the per-element descriptor table.
package rm_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // March element index, E0..E5 are used.
  typedef logic [2:0] elem_t;

  localparam elem_t ELEM_FIRST = 3'd0;
  localparam elem_t ELEM_LAST  = 3'd5;

  // One March element: address direction, optional read with its expected
  // polarity, optional write with its data polarity, and ops per address.
  typedef struct packed {
    logic       desc;     // 1 = descending address order
    logic       has_rd;   // element starts with a read
    logic       rd_val;   // expected read polarity
    logic       has_wr;   // element contains a write
    logic       wr_val;   // written polarity
    logic [1:0] op_cnt;   // operations per address (1 or 2)
  } elem_desc_t;

  // March C-: up(w0) up(r0,w1) up(r1,w0) dn(r0,w1) dn(r1,w0) up(r0).
  // Entries 6 and 7 are padding so any 3-bit index is in range.
  localparam elem_desc_t ELEM_TAB [8] = '{
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2},
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2},
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2},
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2},
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1},
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1},
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1}
  };

endpackage

// File: rtl/rm_bist_cmp.sv
// Read-compare and fail log. The read request (valid, expected, address)
// is registered on the edge the SRAM samples it; the returned data is
// compared during the following cycle and the log updates on the next edge.
module rm_bist_cmp
  import rm_bist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] expected_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              pass_o,
  output logic [7:0]        fail_cnt_o,
  output logic [ADDR_W-1:0] fail_addr_o
);

  logic              pend_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              mismatch;

  // A pending read whose returned data differs from the expected pattern.
  always_comb begin
    mismatch = pend_q && (data_i != exp_q);
  end

  // Pending-read pipeline plus sticky pass, saturating count, first-fail address.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q      <= 1'b0;
      exp_q       <= '0;
      paddr_q     <= '0;
      pass_o      <= 1'b0;
      fail_cnt_o  <= 8'd0;
      fail_addr_o <= '0;
    end else if (clear_i) begin
      pend_q      <= 1'b0;
      exp_q       <= '0;
      paddr_q     <= '0;
      pass_o      <= 1'b1;
      fail_cnt_o  <= 8'd0;
      fail_addr_o <= '0;
    end else begin
      pend_q  <= valid_i;
      exp_q   <= expected_i;
      paddr_q <= addr_i;
      if (mismatch) begin
        pass_o <= 1'b0;
        if (fail_cnt_o != 8'hFF) begin
          fail_cnt_o <= fail_cnt_o + 8'd1;
        end
        // pass_o still high means this is the first mismatch of the test.
        if (pass_o) begin
          fail_addr_o <= paddr_q;
        end
      end
    end
  end

endmodule

// File: rtl/rm_bist_march_ctrl.sv
// March C- BIST controller for a single-port SRAM clocked by clk_i
// (A_BIST_CLK). One SRAM operation per cycle in RUN, one DRAIN cycle for
// the final compare, then DONE holds the verdict until the next start.
module rm_bist_march_ctrl
  import rm_bist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [7:0]        fail_cnt_o,
  output logic              bist_en_o,
  output logic              bist_men_o,
  output logic              bist_wen_o,
  output logic              bist_ren_o,
  output logic [ADDR_W-1:0] bist_addr_o,
  output logic [DATA_W-1:0] bist_din_o,
  output logic [DATA_W-1:0] bist_bm_o,
  input  logic [DATA_W-1:0] bist_dout_i
);

  bist_state_e       state_q, state_d;
  elem_t             elem_q, elem_d, elem_inc;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_term;
  logic              op_q, op_d;        // op index within the current address
  logic              last_op;
  logic              clear;
  logic              run_d, rd_d, wr_d;
  logic [DATA_W-1:0] rd_exp_q;

  // Next-state: element / address / op sequencing and FSM transitions.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    addr_d    = addr_q;
    op_d      = op_q;
    clear     = 1'b0;
    elem_inc  = elem_q + 3'd1;
    addr_term = ELEM_TAB[elem_q].desc ? '0 : '1;
    last_op   = (({1'b0, op_q} + 2'd1) == ELEM_TAB[elem_q].op_cnt);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_RUN;
          elem_d  = ELEM_FIRST;
          addr_d  = ELEM_TAB[ELEM_FIRST].desc ? '1 : '0;
          op_d    = 1'b0;
          clear   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!last_op) begin
          op_d = 1'b1;
        end else if (addr_q == addr_term) begin
          op_d = 1'b0;
          if (elem_q == ELEM_LAST) begin
            state_d = ST_DRAIN;
          end else begin
            elem_d = elem_inc;
            addr_d = ELEM_TAB[elem_inc].desc ? '1 : '0;
          end
        end else begin
          op_d   = 1'b0;
          addr_d = ELEM_TAB[elem_q].desc ? addr_q - 1'b1 : addr_q + 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    // Operation that the bus registers will present next cycle.
    run_d = (state_d == ST_RUN);
    rd_d  = run_d && ELEM_TAB[elem_d].has_rd && !op_d;
    wr_d  = run_d && ELEM_TAB[elem_d].has_wr && !rd_d;
  end

  // State, sequencing and all SRAM-side output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      elem_q      <= ELEM_FIRST;
      addr_q      <= '0;
      op_q        <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      bist_en_o   <= 1'b0;
      bist_men_o  <= 1'b0;
      bist_wen_o  <= 1'b0;
      bist_ren_o  <= 1'b0;
      bist_addr_o <= '0;
      bist_din_o  <= '0;
      bist_bm_o   <= '0;
      rd_exp_q    <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      busy_o      <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_o      <= (state_d == ST_DONE);
      bist_en_o   <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      bist_men_o  <= rd_d || wr_d;
      bist_wen_o  <= wr_d;
      bist_ren_o  <= rd_d;
      bist_addr_o <= run_d ? addr_d : '0;
      bist_din_o  <= wr_d ? {DATA_W{ELEM_TAB[elem_d].wr_val}} : '0;
      bist_bm_o   <= wr_d ? '1 : '0;
      rd_exp_q    <= rd_d ? {DATA_W{ELEM_TAB[elem_d].rd_val}} : '0;
    end
  end

  rm_bist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmp (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear),
    .valid_i    (bist_ren_o),
    .expected_i (rd_exp_q),
    .data_i     (bist_dout_i),
    .addr_i     (bist_addr_o),
    .pass_o     (pass_o),
    .fail_cnt_o (fail_cnt_o),
    .fail_addr_o(fail_addr_o)
  );

endmodule

// File: tb/tb_rm_bist_march_ctrl.sv
// Directed bench for rm_bist_march_ctrl with a behavioural SRAM model
// (optional stuck-at bit and all-ones read fault) and a result scoreboard.
module tb_rm_bist_march_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DONE_LAT = 10 * DEPTH + 1;
  localparam logic [ADDR_W-1:0] STUCK_ADDR = 10'h155;

  logic              clk;
  logic              rst_ni;
  logic              start_i;
  logic              busy_o, done_o, pass_o;
  logic [ADDR_W-1:0] fail_addr_o;
  logic [7:0]        fail_cnt_o;
  logic              bist_en_o, bist_men_o, bist_wen_o, bist_ren_o;
  logic [ADDR_W-1:0] bist_addr_o;
  logic [DATA_W-1:0] bist_din_o, bist_bm_o, bist_dout_i;

  int tests = 0;
  int fails = 0;

  // Scoreboard: {pass, fail_cnt, fail_addr} per launched test.
  logic [18:0] exp_q[$];
  logic [11:0] seq_exp[$];
  logic [11:0] seq_obs[$];

  bit          stuck_en = 1'b0;
  bit          ones_en  = 1'b0;
  bit [DATA_W-1:0] mem [DEPTH];

  rm_bist_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .fail_addr_o(fail_addr_o),
    .fail_cnt_o (fail_cnt_o),
    .bist_en_o  (bist_en_o),
    .bist_men_o (bist_men_o),
    .bist_wen_o (bist_wen_o),
    .bist_ren_o (bist_ren_o),
    .bist_addr_o(bist_addr_o),
    .bist_din_o (bist_din_o),
    .bist_bm_o  (bist_bm_o),
    .bist_dout_i(bist_dout_i)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM model with optional read faults.
  always @(posedge clk) begin
    if (bist_men_o && bist_wen_o)
      mem[bist_addr_o] <= (bist_din_o & bist_bm_o) | (mem[bist_addr_o] & ~bist_bm_o);
    if (bist_men_o && bist_ren_o) begin
      if (ones_en)
        bist_dout_i <= '1;
      else if (stuck_en && bist_addr_o == STUCK_ADDR)
        bist_dout_i <= mem[bist_addr_o] | 32'h0000_0020;
      else
        bist_dout_i <= mem[bist_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: pulse start, then step cycle by cycle until done_o, a reset
  // point or the cycle budget. n counts edges after the start-sampling edge.
  task automatic run_test(input int pa, input int pb, input int rst_at, input bit rec,
                          output int lat, output int nrd, output int nwr, output int bad_bm);
    int n;
    bit stop;
    lat = -1; nrd = 0; nwr = 0; bad_bm = 0; stop = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    n = 0;
    while (!stop && n < 12000) begin
      if (bist_men_o && bist_ren_o) nrd++;
      if (bist_men_o && bist_wen_o) begin
        nwr++;
        if (bist_bm_o !== '1) bad_bm++;
      end
      if (rec && n >= 5119 && n <= 5122)
        seq_obs.push_back({bist_addr_o, bist_wen_o, bist_ren_o});
      start_i = (n == pa || n == pb);
      if (rst_at >= 0 && n == rst_at) rst_ni = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (rst_at >= 0 && n == rst_at + 1) begin
        rst_ni = 1'b1;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_men", {31'd0, bist_men_o}, 32'd0);
        check("abort_done", {31'd0, done_o}, 32'd0);
        stop = 1'b1;
      end else if (done_o) begin
        lat = n;
        stop = 1'b1;
      end
    end
    start_i = 1'b0;
    if (!stop) check("timeout", 32'd1, 32'd0);
  endtask

  // Scoreboard pop: compare verdict against the expected entry.
  task automatic score(input string tag);
    logic [18:0] e;
    check({tag, "_sb_nonempty"}, {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_pass"}, {31'd0, pass_o}, {31'd0, e[18]});
      check({tag, "_cnt"}, {24'd0, fail_cnt_o}, {24'd0, e[17:10]});
      check({tag, "_faddr"}, {22'd0, fail_addr_o}, {22'd0, e[9:0]});
      check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
      check({tag, "_en"}, {31'd0, bist_en_o}, 32'd0);
    end
  endtask

  initial begin
    int lat, nrd, nwr, bad_bm;
    logic [11:0] so, se;
    start_i = 1'b0;
    rst_ni  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_pass", {31'd0, pass_o}, 32'd0);
    check("rst_strobes", {28'd0, bist_en_o, bist_men_o, bist_wen_o, bist_ren_o}, 32'd0);
    check("rst_addr", {22'd0, bist_addr_o}, 32'd0);
    check("rst_din", bist_din_o, 32'd0);
    check("rst_bm", bist_bm_o, 32'd0);
    check("rst_faddr", {22'd0, fail_addr_o}, 32'd0);
    check("rst_fcnt", {24'd0, fail_cnt_o}, 32'd0);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk);

    // Clean memory, with address-sequence capture across E2 -> E3.
    exp_q.push_back({1'b1, 8'd0, 10'd0});
    seq_exp.push_back({10'd1023, 1'b1, 1'b0});
    seq_exp.push_back({10'd1023, 1'b0, 1'b1});
    seq_exp.push_back({10'd1023, 1'b1, 1'b0});
    seq_exp.push_back({10'd1022, 1'b0, 1'b1});
    run_test(-1, -1, -1, 1'b1, lat, nrd, nwr, bad_bm);
    check("clean_lat", lat, DONE_LAT);
    check("clean_reads", nrd, 5 * DEPTH);
    check("clean_writes", nwr, 5 * DEPTH);
    check("clean_bm", bad_bm, 0);
    score("clean");
    check("seq_len", seq_obs.size(), 4);
    while (seq_exp.size() != 0 && seq_obs.size() != 0) begin
      se = seq_exp.pop_front();
      so = seq_obs.pop_front();
      check("addr_seq", {20'd0, so}, {20'd0, se});
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", {31'd0, done_o}, 32'd1);

    // Stuck-at-1 on bit 5 of 0x155: fails the three r0 reads.
    stuck_en = 1'b1;
    exp_q.push_back({1'b0, 8'd3, STUCK_ADDR});
    run_test(-1, -1, -1, 1'b0, lat, nrd, nwr, bad_bm);
    check("stuck_lat", lat, DONE_LAT);
    score("stuck");
    stuck_en = 1'b0;

    // Every read returns all ones: count saturates, first fail at 0.
    ones_en = 1'b1;
    exp_q.push_back({1'b0, 8'd255, 10'd0});
    run_test(-1, -1, -1, 1'b0, lat, nrd, nwr, bad_bm);
    check("sat_lat", lat, DONE_LAT);
    score("sat");

    // Reset mid-run (fault still active), then a fresh clean run.
    run_test(-1, -1, 3000, 1'b0, lat, nrd, nwr, bad_bm);
    ones_en = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.push_back({1'b1, 8'd0, 10'd0});
    run_test(-1, -1, -1, 1'b0, lat, nrd, nwr, bad_bm);
    check("post_rst_lat", lat, DONE_LAT);
    score("post_rst");

    // Start re-pulsed while in RUN and while in DRAIN: must be ignored.
    exp_q.push_back({1'b1, 8'd0, 10'd0});
    run_test(500, 10 * DEPTH, -1, 1'b0, lat, nrd, nwr, bad_bm);
    check("busy_start_lat", lat, DONE_LAT);
    score("busy_start");

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rm_bist_march_ctrl.md
RM_BIST_MARCH_CTRL -- requirements
Module: rm_bist_march_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32: SRAM data and bit-mask width.
REQ-003 SHALL have a single clock port `clk_i`, input, 1 bit; all logic is on its rising edge and it is the same clock that drives A_BIST_CLK.
REQ-004 SHALL have `rst_ni`, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have `start_i`, input, 1 bit: a one-cycle pulse that launches a test.
REQ-006 SHALL have `busy_o`, output, 1 bit: a test is in progress.
REQ-007 SHALL have `done_o`, output, 1 bit: the test has completed; it stays high until the next start or reset.
REQ-008 SHALL have `pass_o`, output, 1 bit: no mismatch was seen; it is valid only when done_o=1.
REQ-009 SHALL have `fail_addr_o`, output, ADDR_W bits: address of the first mismatch.
REQ-010 SHALL have `fail_cnt_o`, output, 8 bits: number of mismatching reads, saturating at 255.
REQ-011 SHALL have `bist_en_o`, `bist_men_o`, `bist_wen_o` and `bist_ren_o`, outputs, 1 bit each, driving A_BIST_EN, A_BIST_MEN, A_BIST_WEN and A_BIST_REN.
REQ-012 SHALL have `bist_addr_o`, output, ADDR_W bits, driving A_BIST_ADDR.
REQ-013 SHALL have `bist_din_o` and `bist_bm_o`, outputs, DATA_W bits each, driving A_BIST_DIN and A_BIST_BM.
REQ-014 SHALL have `bist_dout_i`, input, DATA_W bits, taken from A_DOUT.

Function
REQ-015 SHALL run the March C- algorithm as six elements in order:
- E0: ascending address, w0.
- E1: ascending, r0 then w1.
- E2: ascending, r1 then w0.
- E3: descending, r0 then w1.
- E4: descending, r1 then w0.
- E5: ascending, r0.
REQ-016 SHALL use data patterns "0" = all bits 0 and "1" = all bits 1 on DATA_W bits.
REQ-017 SHALL drive bist_bm_o to all ones whenever bist_wen_o=1.
REQ-018 SHALL issue exactly one SRAM operation per cycle while in RUN:
- read: men=1, ren=1, wen=0.
- write: men=1, wen=1, ren=0.
REQ-019 SHALL, in E1–E4, perform the read and the write to the same address in consecutive cycles before the address steps.
REQ-020 SHALL step addresses as follows:
- Ascending elements run from 0 to 2^ADDR_W-1.
- Descending elements run from 2^ADDR_W-1 to 0.
- Reaching the terminal address advances to the next element without an idle cycle.
REQ-021 SHALL make a RUN phase of exactly 10·2^ADDR_W cycles (10240 at default).
REQ-022 SHALL compare read data one cycle after the read is issued:
- The expected value and a valid flag are registered at issue.
- bist_dout_i is compared in the following cycle.
REQ-023 SHALL handle a mismatch as follows:
- pass is cleared (sticky).
- fail_cnt increments, saturating at 255.
- fail_addr latches the failing read's address only if this is the first mismatch of the test.
REQ-024 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE:
- IDLE→RUN on start_i.
- RUN→DRAIN after the last E5 read.
- DRAIN→DONE after exactly one cycle, during which the final compare occurs.
- DONE→RUN on start_i.
REQ-025 SHALL, on entry to RUN, clear pass to 1, fail_cnt to 0 and fail_addr to 0.
REQ-026 SHALL ignore start_i while in RUN or DRAIN.
REQ-027 SHALL drive busy_o=1 in RUN and DRAIN, and done_o=1 only in DONE.
REQ-028 SHALL hold bist_en_o=1 in RUN and DRAIN, and 0 otherwise.
REQ-029 SHALL hold men, wen and ren at 0 outside RUN, and at 0 during DRAIN.
REQ-030 SHALL register all SRAM-side outputs, with no combinational path from bist_dout_i or start_i to any output.

Reset
REQ-031 SHALL, on rst_ni=0 at a clock edge, force:
- state to IDLE.
- busy_o, done_o, pass_o, bist_en_o, bist_men_o, bist_wen_o and bist_ren_o to 0.
- bist_addr_o, bist_din_o, bist_bm_o, fail_addr_o and fail_cnt_o to 0.
REQ-032 SHALL abort any test when reset is asserted mid-operation, with no further SRAM access and no pending compare retained.

Structure
REQ-033 SHALL place the FSM state enum, the element index type (3 bits, E0–E5) and the per-element descriptor table (direction, read polarity, write polarity, op count) in shared package rm_bist_pkg.
REQ-034 SHALL implement the read-compare and fail-log logic as one sub-module, rm_bist_cmp, which takes valid, expected, data and address and outputs pass, fail_cnt and fail_addr.

Verification
REQ-035 SHALL cover a clean-memory case: start_i pulse with a fault-free model → done_o asserts 10241 cycles after start, with pass_o=1 and fail_cnt_o=0.
REQ-036 SHALL cover a single stuck-at fault: bit 5 of address 0x155 stuck at 1 → pass_o=0, fail_addr_o=0x155 and fail_cnt_o=3 (the r0 reads in E1, E3 and E5).
REQ-037 SHALL cover fail-count saturation: all reads return 32'hFFFF_FFFF → fail_cnt_o=255, fail_addr_o=0 and pass_o=0.
REQ-038 SHALL cover reset mid-operation: rst_ni=0 for one cycle at RUN cycle 3000 → next cycle has busy_o=0, bist_men_o=0 and done_o=0, and a fresh start then passes.
REQ-039 SHALL cover start while busy: start_i re-pulsed during RUN and during DRAIN → no restart, and done_o still asserts at cycle 10241.
REQ-040 SHALL cover the address sequence: monitor bist_addr_o at E2→E3 → the sequence is 1023(w0), 1023(r0), 1023(w1), 1022(r0).
